pc_unit_ras: RTL and testbench
==============================

// Module: pc_unit_ras
// PURPOSE
//  Next-generation PC control for the multi-cycle core: decodes branch/jump/call/ret,
//  owns the PC register and a parametrised hardware return-address stack (RAS).
//  CALL pushes PC+1 and RET pops it, so RET no longer needs an external return register.
//  Sits between the control FSM (pc_write strobe), ALU flags and instruction decode.
// PARAMETERS
//  PC_W      32  PC / address width
//  OP_W      6   opcode width
//  RAS_DEPTH 8   return stack entries (power of 2, >=2)
//  RESET_PC  0   PC value after reset
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous, active-low reset
//  pc_write     in   1          commit next PC on this edge (one pulse per instruction)
//  opcode       in   OP_W       current instruction opcode
//  carry        in   1          ALU carry flag of compare
//  zero         in   1          ALU zero flag of compare
//  br_offset    in   PC_W       sign-extended branch offset
//  jmp_target   in   PC_W       absolute jump/call target
//  err_clr      in   1          clears sticky RAS error flags
//  pc           out  PC_W       current PC (registered)
//  pcsrc        out  2          0=PC+1, 1=jump/call, 2=branch taken, 3=ret (combinational)
//  ras_count    out  $clog2(RAS_DEPTH)+1  valid stack entries
//  ras_full     out  1          ras_count==RAS_DEPTH
//  ras_empty    out  1          ras_count==0
//  ras_overflow out  1          sticky: CALL committed while full
//  ras_underflow out 1          sticky: RET committed while empty
// BEHAVIOUR
//  Reset (rst_n=0, any time, async): pc=RESET_PC, ras_count=0, both error flags 0;
//   stack contents don't-care. Reset mid-instruction aborts any pending commit.
//  Decode (combinational, from opcode/carry/zero):
//   BGT op 8: taken if carry=1 & zero=0 | BLT op 9: taken if carry=0 & zero=0
//   BEQ op 10: taken if zero=1 | BNE op 11: taken if zero=0
//   JMP op 12 -> pcsrc=1 | CALL op 13 -> pcsrc=1 | RET op 14 -> pcsrc=3
//   branch taken -> pcsrc=2; everything else / not taken -> pcsrc=0.
//  Next PC: 0: pc+1; 1: jmp_target; 2: pc+br_offset; 3: RAS top.
//   All adds modulo 2^PC_W (wrap silently, no flag).
//  Commit: pc and RAS change only on a clk edge with pc_write=1; pc_write=0 holds all state.
//   Latency: pc shows new value the cycle after the pc_write edge.
//  CALL commit: push pc+1, ras_count+1, pc<=jmp_target.
//   If ras_full: push dropped, count unchanged, ras_overflow<=1, pc<=jmp_target still.
//  RET commit: pc<=top, ras_count-1.
//   If ras_empty: pcsrc still 3 but pc<=pc+1 (NOP), ras_underflow<=1, count stays 0.
//  RAS is a LIFO array + pointer; top = entry[count-1]; no read of stale entries.
//  err_clr: clears both sticky flags at next edge.
//   Same-edge new error with err_clr: error wins (flag =1).
//  Opcodes 0..7, 15..2^OP_W-1: sequential PC+1, RAS untouched.
// TESTING
//  1 reset: rst_n=0 -> pc=RESET_PC, ras_empty=1, flags=0; release, 3x pc_write op 0 -> pc=3.
//  2 branches: pc=10, op 10 zero=1 br_offset=-4 -> pc=6; op 8 carry=0 -> pc=7 (not taken).
//  3 call/ret: pc=20 CALL jmp_target=100 -> pc=100, count=1; RET -> pc=21, count=0.
//  4 overflow: RAS_DEPTH+1 nested CALLs -> ras_overflow=1, count=RAS_DEPTH;
//    RAS_DEPTH RETs unwind in LIFO order.
//  5 underflow+clr: RET on empty at pc=5 -> pc=6, ras_underflow=1;
//    err_clr with another empty RET -> flag stays 1.
//  6 wrap/async: pc=2^PC_W-1 op 0 -> pc=0; assert rst_n mid-cycle after CALL -> immediate pc=RESET_PC, count=0.

Source files
------------

// File: rtl/pc_unit_ras.sv
// PC control for the multi-cycle core: branch/jump/call/ret decode, PC register,
// and a hardware return-address stack so RET needs no external return register.
module pc_unit_ras #(
   parameter int unsigned          PC_W      = 32,
   parameter int unsigned          OP_W      = 6,
   parameter int unsigned          RAS_DEPTH = 8,
   parameter logic [PC_W-1:0]      RESET_PC  = '0,
   localparam int unsigned         CNT_W     = $clog2(RAS_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_write,
   input  logic [OP_W-1:0]   opcode,
   input  logic              carry,
   input  logic              zero,
   input  logic [PC_W-1:0]   br_offset,
   input  logic [PC_W-1:0]   jmp_target,
   input  logic              err_clr,
   output logic [PC_W-1:0]   pc,
   output logic [1:0]        pcsrc,
   output logic [CNT_W-1:0]  ras_count,
   output logic              ras_full,
   output logic              ras_empty,
   output logic              ras_overflow,
   output logic              ras_underflow
);

   localparam int unsigned IDX_W = $clog2(RAS_DEPTH);

   localparam logic [OP_W-1:0] OP_BGT  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_BLT  = OP_W'(9);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_BNE  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_JMP  = OP_W'(12);
   localparam logic [OP_W-1:0] OP_CALL = OP_W'(13);
   localparam logic [OP_W-1:0] OP_RET  = OP_W'(14);

   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'd0,
      PCSRC_JMP = 2'd1,
      PCSRC_BR  = 2'd2,
      PCSRC_RET = 2'd3
   } pcsrc_e;

   pcsrc_e            sel;
   logic              is_call;
   logic              is_ret;
   logic [PC_W-1:0]   pc_plus1;
   logic [PC_W-1:0]   ras_top;
   logic [PC_W-1:0]   next_pc;
   logic [IDX_W-1:0]  top_idx;
   logic [IDX_W-1:0]  push_idx;
   logic [PC_W-1:0]   ras_mem [RAS_DEPTH];

   assign pc_plus1  = pc + PC_W'(1);
   assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
   assign ras_empty = (ras_count == '0);
   assign top_idx   = IDX_W'(ras_count - CNT_W'(1));
   assign push_idx  = ras_count[IDX_W-1:0];
   assign ras_top   = ras_mem[top_idx];
   assign pcsrc     = sel;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      sel     = PCSRC_SEQ;
      is_call = 1'b0;
      is_ret  = 1'b0;
      case (opcode)
         OP_BGT:  if (carry && !zero)  sel = PCSRC_BR;
         OP_BLT:  if (!carry && !zero) sel = PCSRC_BR;
         OP_BEQ:  if (zero)            sel = PCSRC_BR;
         OP_BNE:  if (!zero)           sel = PCSRC_BR;
         OP_JMP:  sel = PCSRC_JMP;
         OP_CALL: begin
            sel     = PCSRC_JMP;
            is_call = 1'b1;
         end
         OP_RET: begin
            sel    = PCSRC_RET;
            is_ret = 1'b1;
         end
         default: sel = PCSRC_SEQ;
      endcase
   end

   // A RET on an empty stack degrades to a NOP rather than reading a stale entry.
   always_comb begin
      next_pc = pc_plus1;
      case (sel)
         PCSRC_JMP: next_pc = jmp_target;
         PCSRC_BR:  next_pc = pc + br_offset;
         PCSRC_RET: next_pc = ras_empty ? pc_plus1 : ras_top;
         default:   next_pc = pc_plus1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_PC;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         if (err_clr) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
         end
         if (pc_write) begin
            pc <= next_pc;
            if (is_call) begin
               if (ras_full) ras_overflow <= 1'b1;
               else          ras_count    <= ras_count + CNT_W'(1);
            end
            if (is_ret) begin
               if (ras_empty) ras_underflow <= 1'b1;
               else           ras_count     <= ras_count - CNT_W'(1);
            end
         end
      end
   end

   // NOTE: stack storage is not reset; entries above ras_count are never read.
   always_ff @(posedge clk) begin
      if (pc_write && is_call && !ras_full) ras_mem[push_idx] <= pc_plus1;
   end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: reset, branches, call/ret, stack overflow and
// underflow with sticky-flag clearing, PC wrap and asynchronous reset.
module tb_pc_unit_ras;

   localparam int PC_W  = 32;
   localparam int OP_W  = 6;
   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pc_write;
   logic [OP_W-1:0]   opcode;
   logic              carry;
   logic              zero;
   logic [PC_W-1:0]   br_offset;
   logic [PC_W-1:0]   jmp_target;
   logic              err_clr;
   logic [PC_W-1:0]   pc;
   logic [1:0]        pcsrc;
   logic [CNT_W-1:0]  ras_count;
   logic              ras_full;
   logic              ras_empty;
   logic              ras_overflow;
   logic              ras_underflow;

   int errors = 0;
   int checks = 0;

   pc_unit_ras #(.PC_W(PC_W), .OP_W(OP_W), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .opcode(opcode),
      .carry(carry), .zero(zero), .br_offset(br_offset), .jmp_target(jmp_target),
      .err_clr(err_clr), .pc(pc), .pcsrc(pcsrc), .ras_count(ras_count),
      .ras_full(ras_full), .ras_empty(ras_empty), .ras_overflow(ras_overflow),
      .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present an instruction at the falling edge; outputs are settled 1 unit later.
   task automatic drive(input int op, input logic c, input logic z,
                        input logic [PC_W-1:0] off, input logic [PC_W-1:0] tgt);
      @(negedge clk);
      opcode     = OP_W'(op);
      carry      = c;
      zero       = z;
      br_offset  = off;
      jmp_target = tgt;
      #1;
   endtask

   // Commit on the next rising edge, then sample at the following falling edge.
   task automatic go();
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
   endtask

   task automatic step(input int op, input logic c, input logic z,
                       input logic [PC_W-1:0] off, input logic [PC_W-1:0] tgt);
      drive(op, c, z, off, tgt);
      go();
   endtask

   logic [PC_W-1:0] exp_ret [DEPTH];

   initial begin
      rst_n = 1'b0; pc_write = 1'b0; opcode = '0; carry = 1'b0; zero = 1'b0;
      br_offset = '0; jmp_target = '0; err_clr = 1'b0;

      // 1: reset state, then three sequential commits
      #12;
      check("reset_pc", pc, 0);
      check("reset_empty", ras_empty, 1);
      check("reset_count", ras_count, 0);
      check("reset_ovf", ras_overflow, 0);
      check("reset_unf", ras_underflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      check("seq_pc3", pc, 3);
      drive(12, 0, 0, 0, 77);
      @(negedge clk);
      check("hold_no_write", pc, 3);

      // 2: branches
      step(12, 0, 0, 0, 10);
      check("jmp_pc10", pc, 10);
      drive(10, 0, 1, -4, 0);
      check("beq_pcsrc", pcsrc, 2);
      go();
      check("beq_pc6", pc, 6);
      drive(8, 0, 0, 5, 0);
      check("bgt_nt_pcsrc", pcsrc, 0);
      go();
      check("bgt_nt_pc7", pc, 7);
      step(9, 0, 0, 3, 0);
      check("blt_t_pc10", pc, 10);
      step(11, 0, 1, 9, 0);
      check("bne_nt_pc11", pc, 11);
      step(8, 1, 0, 5, 0);
      check("bgt_t_pc16", pc, 16);

      // 3: call / ret
      step(12, 0, 0, 0, 20);
      drive(13, 0, 0, 0, 100);
      check("call_pcsrc", pcsrc, 1);
      go();
      check("call_pc", pc, 100);
      check("call_count", ras_count, 1);
      drive(14, 0, 0, 0, 0);
      check("ret_pcsrc", pcsrc, 3);
      go();
      check("ret_pc", pc, 21);
      check("ret_count", ras_count, 0);

      // 4: DEPTH+1 nested calls from pc=21; the last push is dropped
      for (int i = 0; i <= DEPTH; i++) begin
         if (i < DEPTH) exp_ret[i] = (i == 0) ? 32'd22 : PC_W'(200 + (i - 1) * 10 + 1);
         if (i == DEPTH) begin
            check("full_before_ovf", ras_full, 1);
            check("ovf_not_yet", ras_overflow, 0);
         end
         step(13, 0, 0, 0, PC_W'(200 + i * 10));
      end
      check("ovf_flag", ras_overflow, 1);
      check("ovf_count", ras_count, DEPTH);
      check("ovf_pc", pc, 280);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         step(14, 0, 0, 0, 0);
         check($sformatf("unwind_%0d", i), pc, exp_ret[i]);
      end
      check("unwind_empty", ras_empty, 1);
      check("ovf_sticky", ras_overflow, 1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("ovf_cleared", ras_overflow, 0);

      // 5: underflow and err_clr collision
      step(12, 0, 0, 0, 5);
      drive(14, 0, 0, 0, 0);
      check("unf_pcsrc", pcsrc, 3);
      go();
      check("unf_pc", pc, 6);
      check("unf_flag", ras_underflow, 1);
      check("unf_count", ras_count, 0);
      drive(14, 0, 0, 0, 0);
      err_clr = 1'b1;
      go();
      err_clr = 1'b0;
      check("unf_clr_collide", ras_underflow, 1);
      check("unf_clr_pc", pc, 7);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("unf_cleared", ras_underflow, 0);

      // 6: wrap, then asynchronous reset mid-cycle with a commit pending
      step(12, 0, 0, 0, 32'hFFFF_FFFF);
      check("wrap_pre", pc, 64'hFFFF_FFFF);
      step(0, 0, 0, 0, 0);
      check("wrap_pc0", pc, 0);
      step(13, 0, 0, 0, 50);
      check("async_pre_pc", pc, 50);
      check("async_pre_cnt", ras_count, 1);
      drive(12, 0, 0, 0, 99);
      pc_write = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("async_pc", pc, 0);
      check("async_count", ras_count, 0);
      @(negedge clk);
      check("abort_commit", pc, 0);
      pc_write = 1'b0;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0);
      check("post_reset_pc1", pc, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
